mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 24 ++
 rtl/mem_loader_agen.sv | 35 +++
 rtl/mem_loader.sv | 137 +++++++++++++
 tb/tb_mem_loader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared definitions for the memory loader: FSM state encodings, command
// opcodes, external memory request types and a word-alignment helper.
package mem_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LOAD     = 3'd1;
  localparam state_t ST_DUMP_RD  = 3'd2;
  localparam state_t ST_DUMP_OUT = 3'd3;
  localparam state_t ST_FIN      = 3'd4;

  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_DUMP = 1'b1;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Byte address rounded down to the containing 32-bit word.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/mem_loader_agen.sv
// Address generator for the memory loader: holds the current word address
// and the remaining word count, advances both by one word on request and
// flags when the word being transferred is the last one.
module mem_loader_agen
  import mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] base,
  input  logic [15:0] len,
  output logic [31:0] addr,
  output logic        last
);

  logic [15:0] count;

  // Latch a new command's start point, or advance one word (address wraps mod 2^32).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr  <= '0;
      count <= '0;
    end else if (load) begin
      addr  <= word_align(base);
      count <= len;
    end else if (step) begin
      addr  <= addr + 32'd4;
      count <= count - 16'd1;
    end
  end

  assign last = (count == 16'd1);

endmodule

// File: rtl/mem_loader.sv
// Memory loader: moves word streams into (LOAD) or out of (DUMP) a processor's
// external data-memory port. The processor must be held in reset while the
// loader is active, because processor requests win on the shared port.
// Optional build macro MEM_LOADER_CHECKSUM_EN enables a running 32-bit sum of
// the transferred words; without it the checksum output is tied to zero.
module mem_loader
  import mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_val,
  output logic        cmd_rdy,
  input  logic        cmd_op,
  input  logic [31:0] cmd_base,
  input  logic [15:0] cmd_len,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [31:0] in_data,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [31:0] out_data,
  output logic        ext_dmemreq_val,
  output logic        ext_dmemreq_type,
  output logic [31:0] ext_dmemreq_addr,
  output logic [31:0] ext_dmemreq_wdata,
  input  logic [31:0] ext_dmemresp_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum
);

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        step;
  logic        last;
  logic [31:0] cur_addr;
  logic [31:0] out_data_q;

  mem_loader_agen u_agen (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .step (step),
    .base (cmd_base),
    .len  (cmd_len),
    .addr (cur_addr),
    .last (last)
  );

  // State register; reset abandons any command in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state, handshakes and memory request decode for the current state.
  always_comb begin
    state_next        = state;
    cmd_rdy           = 1'b0;
    in_rdy            = 1'b0;
    out_val           = 1'b0;
    done              = 1'b0;
    accept            = 1'b0;
    step              = 1'b0;
    ext_dmemreq_val   = 1'b0;
    ext_dmemreq_type  = MEM_READ;
    ext_dmemreq_addr  = '0;
    ext_dmemreq_wdata = '0;
    case (state)
      ST_IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_val) begin
          accept = 1'b1;
          if (cmd_len == 16'd0)     state_next = ST_FIN;
          else if (cmd_op == OP_DUMP) state_next = ST_DUMP_RD;
          else                        state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_rdy = 1'b1;
        if (in_val) begin
          ext_dmemreq_val   = 1'b1;
          ext_dmemreq_type  = MEM_WRITE;
          ext_dmemreq_addr  = cur_addr;
          ext_dmemreq_wdata = in_data;
          step              = 1'b1;
          if (last) state_next = ST_FIN;
        end
      end
      ST_DUMP_RD: begin
        ext_dmemreq_val  = 1'b1;
        ext_dmemreq_type = MEM_READ;
        ext_dmemreq_addr = cur_addr;
        state_next       = ST_DUMP_OUT;
      end
      ST_DUMP_OUT: begin
        out_val = 1'b1;
        if (out_rdy) begin
          step       = 1'b1;
          state_next = last ? ST_FIN : ST_DUMP_RD;
        end
      end
      ST_FIN: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture read data in the read cycle so it stays stable while the stream stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      out_data_q <= '0;
    else if (state == ST_DUMP_RD)  out_data_q <= ext_dmemresp_rdata;
  end

  assign out_data = out_data_q;
  assign busy     = (state != ST_IDLE);

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;

  // Running sum of words written or delivered, restarted on each accepted command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  sum_q <= '0;
    else if (accept)                           sum_q <= '0;
    else if (state == ST_LOAD && in_val)       sum_q <= sum_q + in_data;
    else if (state == ST_DUMP_OUT && out_rdy)  sum_q <= sum_q + out_data_q;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Directed self-checking bench for mem_loader. Inputs change and outputs are
// sampled on the falling clock edge; a small read-only memory model answers
// read requests combinationally and a monitor counts requests and done pulses.
module tb_mem_loader;

  logic        clk;
  logic        rst;
  logic        cmd_val;
  logic        cmd_rdy;
  logic        cmd_op;
  logic [31:0] cmd_base;
  logic [15:0] cmd_len;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] in_data;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_data;
  logic        ext_dmemreq_val;
  logic        ext_dmemreq_type;
  logic [31:0] ext_dmemreq_addr;
  logic [31:0] ext_dmemreq_wdata;
  logic [31:0] ext_dmemresp_rdata;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  logic [31:0] mem [0:255];
  int          checks;
  int          errors;
  int          req_count;
  int          rd_count;
  int          done_count;
  int          req_snap;
  int          rd_snap;
  int          done_snap;

  mem_loader dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_val            (cmd_val),
    .cmd_rdy            (cmd_rdy),
    .cmd_op             (cmd_op),
    .cmd_base           (cmd_base),
    .cmd_len            (cmd_len),
    .in_val             (in_val),
    .in_rdy             (in_rdy),
    .in_data            (in_data),
    .out_val            (out_val),
    .out_rdy            (out_rdy),
    .out_data           (out_data),
    .ext_dmemreq_val    (ext_dmemreq_val),
    .ext_dmemreq_type   (ext_dmemreq_type),
    .ext_dmemreq_addr   (ext_dmemreq_addr),
    .ext_dmemreq_wdata  (ext_dmemreq_wdata),
    .ext_dmemresp_rdata (ext_dmemresp_rdata),
    .busy               (busy),
    .done               (done),
    .checksum           (checksum)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational read port of the memory model.
  assign ext_dmemresp_rdata = mem[ext_dmemreq_addr[9:2]];

  // Count memory requests, reads and done pulses seen at each rising edge.
  always @(posedge clk) begin
    if (ext_dmemreq_val) begin
      req_count++;
      if (!ext_dmemreq_type) rd_count++;
    end
    if (done) done_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      $error("[TB] %s observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present one command at the current falling edge and return one cycle later.
  task automatic applyStimulus(input logic op, input logic [31:0] base, input logic [15:0] len);
    cmd_val  = 1'b1;
    cmd_op   = op;
    cmd_base = base;
    cmd_len  = len;
    checkOutput("cmd_rdy_idle", {31'd0, cmd_rdy}, 32'd1);
    @(negedge clk);
    cmd_val = 1'b0;
  endtask

  function automatic logic [31:0] exp_sum(input logic [31:0] s);
`ifdef MEM_LOADER_CHECKSUM_EN
    return s;
`else
    return (s & 32'd0);
`endif
  endfunction

  initial begin
    checks     = 0;
    errors     = 0;
    req_count  = 0;
    rd_count   = 0;
    done_count = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 + i;
    mem[8'h40] = 32'h0000_000A;
    mem[8'h41] = 32'h0000_000B;
    mem[8'h42] = 32'h0000_000C;
    rst      = 1'b0;
    cmd_val  = 1'b0;
    cmd_op   = 1'b0;
    cmd_base = '0;
    cmd_len  = '0;
    in_val   = 1'b0;
    in_data  = '0;
    out_rdy  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_busy",     {31'd0, busy}, 32'd0);
    checkOutput("rst_done",     {31'd0, done}, 32'd0);
    checkOutput("rst_in_rdy",   {31'd0, in_rdy}, 32'd0);
    checkOutput("rst_out_val",  {31'd0, out_val}, 32'd0);
    checkOutput("rst_req_val",  {31'd0, ext_dmemreq_val}, 32'd0);
    checkOutput("rst_req_addr", ext_dmemreq_addr, 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_checksum", checksum, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);

    // LOAD base 0x100, three words; a stray command while busy must be ignored
    $display("[TB] LOAD 0x100 x3");
    applyStimulus(1'b0, 32'h0000_0100, 16'd3);
    req_snap  = req_count;
    cmd_val   = 1'b1;
    cmd_op    = 1'b1;
    cmd_len   = 16'd9;
    in_val    = 1'b1;
    in_data   = 32'h0000_000A;
    #1;
    checkOutput("load_busy",    {31'd0, busy}, 32'd1);
    checkOutput("load_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    checkOutput("load_in_rdy",  {31'd0, in_rdy}, 32'd1);
    checkOutput("load0_val",    {31'd0, ext_dmemreq_val}, 32'd1);
    checkOutput("load0_type",   {31'd0, ext_dmemreq_type}, 32'd1);
    checkOutput("load0_addr",   ext_dmemreq_addr, 32'h0000_0100);
    checkOutput("load0_wdata",  ext_dmemreq_wdata, 32'h0000_000A);
    @(negedge clk);
    cmd_val = 1'b0;
    in_data = 32'h0000_000B;
    #1;
    checkOutput("load1_addr",  ext_dmemreq_addr, 32'h0000_0104);
    checkOutput("load1_wdata", ext_dmemreq_wdata, 32'h0000_000B);
    @(negedge clk);
    in_data = 32'h0000_000C;
    #1;
    checkOutput("load2_addr",  ext_dmemreq_addr, 32'h0000_0108);
    checkOutput("load2_wdata", ext_dmemreq_wdata, 32'h0000_000C);
    @(negedge clk);
    in_val = 1'b0;
    #1;
    checkOutput("load_done",     {31'd0, done}, 32'd1);
    checkOutput("load_fin_req",  {31'd0, ext_dmemreq_val}, 32'd0);
    checkOutput("load_fin_rdy",  {31'd0, in_rdy}, 32'd0);
    checkOutput("load_checksum", checksum, exp_sum(32'h0000_0021));
    checkOutput("load_nreq",     req_count - req_snap, 32'd3);
    @(negedge clk);
    checkOutput("load_done_clr", {31'd0, done}, 32'd0);
    checkOutput("load_idle",     {31'd0, busy}, 32'd0);
    checkOutput("load_sum_hold", checksum, exp_sum(32'h0000_0021));

    // DUMP base 0x100, three words with one stall on the second word
    $display("[TB] DUMP 0x100 x3");
    rd_snap   = rd_count;
    done_snap = done_count;
    applyStimulus(1'b1, 32'h0000_0100, 16'd3);
    checkOutput("dump0_val",     {31'd0, ext_dmemreq_val}, 32'd1);
    checkOutput("dump0_type",    {31'd0, ext_dmemreq_type}, 32'd0);
    checkOutput("dump0_addr",    ext_dmemreq_addr, 32'h0000_0100);
    checkOutput("dump0_out_val", {31'd0, out_val}, 32'd0);
    @(negedge clk);
    checkOutput("dump0_ov",   {31'd0, out_val}, 32'd1);
    checkOutput("dump0_data", out_data, 32'h0000_000A);
    checkOutput("dump0_noreq", {31'd0, ext_dmemreq_val}, 32'd0);
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    checkOutput("dump1_addr", ext_dmemreq_addr, 32'h0000_0104);
    @(negedge clk);
    checkOutput("dump1_data", out_data, 32'h0000_000B);
    @(negedge clk);
    checkOutput("dump1_stall_ov",   {31'd0, out_val}, 32'd1);
    checkOutput("dump1_stall_data", out_data, 32'h0000_000B);
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    checkOutput("dump2_addr", ext_dmemreq_addr, 32'h0000_0108);
    @(negedge clk);
    checkOutput("dump2_data", out_data, 32'h0000_000C);
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    checkOutput("dump_done",     {31'd0, done}, 32'd1);
    checkOutput("dump_fin_ov",   {31'd0, out_val}, 32'd0);
    checkOutput("dump_nreads",   rd_count - rd_snap, 32'd3);
    checkOutput("dump_checksum", checksum, exp_sum(32'h0000_0021));
    @(negedge clk);
    checkOutput("dump_ndone", done_count - done_snap, 32'd1);

    // Zero-length command: done next cycle, no memory traffic, sum restarted
    $display("[TB] zero length");
    req_snap = req_count;
    applyStimulus(1'b0, 32'h0000_0100, 16'd0);
    checkOutput("len0_done",     {31'd0, done}, 32'd1);
    checkOutput("len0_req",      {31'd0, ext_dmemreq_val}, 32'd0);
    checkOutput("len0_checksum", checksum, 32'd0);
    @(negedge clk);
    checkOutput("len0_idle", {31'd0, busy}, 32'd0);
    checkOutput("len0_nreq", req_count - req_snap, 32'd0);

    // Address wrap at the top of the address space
    $display("[TB] LOAD wrap");
    applyStimulus(1'b0, 32'hFFFF_FFFC, 16'd2);
    in_val  = 1'b1;
    in_data = 32'h0000_0001;
    #1;
    checkOutput("wrap0_addr", ext_dmemreq_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    in_data = 32'h0000_0002;
    #1;
    checkOutput("wrap1_addr",  ext_dmemreq_addr, 32'h0000_0000);
    checkOutput("wrap1_wdata", ext_dmemreq_wdata, 32'h0000_0002);
    @(negedge clk);
    in_val = 1'b0;
    checkOutput("wrap_done",     {31'd0, done}, 32'd1);
    checkOutput("wrap_checksum", checksum, exp_sum(32'h0000_0003));
    @(negedge clk);

    // Unaligned base is rounded down to the word
    $display("[TB] unaligned base");
    applyStimulus(1'b1, 32'h0000_0103, 16'd1);
    checkOutput("unal_addr", ext_dmemreq_addr, 32'h0000_0100);
    checkOutput("unal_type", {31'd0, ext_dmemreq_type}, 32'd0);
    @(negedge clk);
    checkOutput("unal_data", out_data, 32'h0000_000A);
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    checkOutput("unal_done", {31'd0, done}, 32'd1);
    @(negedge clk);

    // Reset after two of four LOAD words abandons the command
    $display("[TB] reset mid-transfer");
    applyStimulus(1'b0, 32'h0000_0200, 16'd4);
    in_val  = 1'b1;
    in_data = 32'h0000_0011;
    @(negedge clk);
    in_data = 32'h0000_0022;
    #1;
    checkOutput("abort1_addr", ext_dmemreq_addr, 32'h0000_0204);
    @(negedge clk);
    in_data   = 32'h0000_0033;
    rst       = 1'b0;
    req_snap  = req_count;
    done_snap = done_count;
    #1;
    checkOutput("abort_busy",    {31'd0, busy}, 32'd0);
    checkOutput("abort_req",     {31'd0, ext_dmemreq_val}, 32'd0);
    checkOutput("abort_in_rdy",  {31'd0, in_rdy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    in_val = 1'b0;
    checkOutput("abort_nreq",    req_count - req_snap, 32'd0);
    checkOutput("abort_ndone",   done_count - done_snap, 32'd0);
    checkOutput("abort_idle",    {31'd0, busy}, 32'd0);
    checkOutput("abort_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    checkOutput("abort_sum",     checksum, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
